uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_tx_fifo.sv | 79 +++++++
 rtl/uart_tx_periph.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_periph.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit peripheral.
package uart_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Register offsets (word index, bus_addr[3:2])
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    // STATUS register bit positions
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 4;

    localparam int unsigned DATA_BITS = 8;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [31:0] status_word(
        input logic                  full,
        input logic                  empty,
        input logic                  busy,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w                                = '0;
        w[STAT_FULL]                     = full;
        w[STAT_EMPTY]                    = empty;
        w[STAT_BUSY]                     = busy;
        w[STAT_OVF]                      = ovf;
        w[STAT_CNT_LSB +: STAT_CNT_W]    = cnt;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a push into a full FIFO is only
// accepted when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Accept/pop qualification, pointer and occupancy update
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: bus decode, STATUS/overflow, serializer FSM.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wrdata,
    input  logic        bus_wren,
    input  logic        bus_rden,
    output logic [31:0] bus_rddata,
    output logic        tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;

    logic             sel_c;
    logic [1:0]       off_c;
    logic             push_c;
    logic             ovf_clr_c;
    logic             pop_c;
    logic             baud_done_c;

    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             unused_c;
    assign unused_c = ^{bus_addr[1:0], bus_wrdata[31:8]};

    // Address decode and write strobes
    always_comb begin
        sel_c     = (bus_addr[31:4] == BASE_ADDR[31:4]);
        off_c     = bus_addr[3:2];
        push_c    = bus_wren && sel_c && (off_c == OFF_TXDATA);
        ovf_clr_c = bus_wren && sel_c && (off_c == OFF_STATUS) && bus_wrdata[STAT_OVF];
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (bus_wrdata[7:0]),
        .pop       (pop_c),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Serializer next state; tx is computed for the state being entered so
    // the line changes on the same edge as the state
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        pop_c       = 1'b0;
        baud_done_c = (baud_q == BAUD_LAST);
        unique case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_data;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_c) begin
                    baud_d = '0;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_c) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Overflow flag: a dropped push wins over a same-edge clear
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_c) begin
            ovf_d = 1'b0;
        end
        if (push_c && fifo_full && !pop_c) begin
            ovf_d = 1'b1;
        end
    end

    // All peripheral state; reset idles the line immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Zero-wait read mux; zero when not addressed so slaves can be OR-ed
    always_comb begin
        bus_rddata = '0;
        if (bus_rden && sel_c && (off_c == OFF_STATUS)) begin
            bus_rddata = status_word(fifo_full, fifo_empty, (state_q != ST_IDLE),
                                     ovf_q, STAT_CNT_W'(fifo_count));
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed + randomized bench for uart_tx_periph with a frame-timing reference model.
module tb_uart_tx_periph;

    localparam int C     = 4;
    localparam int D     = 8;
    localparam int FRAME = 10 * C;
    localparam logic [31:0] BASE    = 32'h1001_0000;
    localparam logic [31:0] A_TX    = BASE;
    localparam logic [31:0] A_ST    = BASE + 32'h4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wrdata = '0;
    logic        bus_wren = 1'b0;
    logic        bus_rden = 1'b0;
    logic [31:0] bus_rddata;
    logic        tx;

    int checks = 0;
    int failures = 0;

    // reference model: queued bytes, edge count, frame start edge of current byte
    logic [7:0] q_m[$];
    int         e_m = 0;
    int         fstart_m = 0;
    bit         busy_m = 0;
    logic [7:0] cur_m = '0;
    bit         ovf_m = 0;

    uart_tx_periph #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_rden   (bus_rden),
        .bus_rddata (bus_rddata),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    function automatic bit in_frame(input int t);
        return busy_m && (t >= fstart_m) && (t < fstart_m + FRAME);
    endfunction

    function automatic logic exp_tx();
        int idx;
        if (!in_frame(e_m)) return 1'b1;
        idx = (e_m - fstart_m) / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cur_m[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w        = '0;
        w[0]     = (q_m.size() == D);
        w[1]     = (q_m.size() == 0);
        w[2]     = in_frame(e_m);
        w[3]     = ovf_m;
        w[11:8]  = 4'(q_m.size());
        return w;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic rd);
        if (rd && (a[31:4] == BASE[31:4]) && (a[3:2] == 2'd1)) return exp_status();
        return 32'h0;
    endfunction

    task automatic model_reset();
        q_m.delete();
        busy_m = 0;
        ovf_m  = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: update model with inputs sampled at the edge, check tx on the falling edge
    task automatic tick();
        bit sel;
        bit pop;
        @(posedge clk);
        e_m++;
        if (rst) begin
            sel = (bus_addr[31:4] == BASE[31:4]);
            pop = !in_frame(e_m - 1) && (q_m.size() != 0);
            if (pop) begin
                cur_m    = q_m.pop_front();
                fstart_m = e_m;
                busy_m   = 1;
            end
            if (bus_wren && sel && bus_addr[3:2] == 2'd1 && bus_wrdata[3]) ovf_m = 0;
            if (bus_wren && sel && bus_addr[3:2] == 2'd0) begin
                if (q_m.size() < D) q_m.push_back(bus_wrdata[7:0]);
                else ovf_m = 1;
            end
        end
        @(negedge clk);
        chk("tx_line", {31'd0, tx}, {31'd0, exp_tx()});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr   = a;
        bus_wrdata = d;
        bus_wren   = 1'b1;
        tick();
        bus_wren   = 1'b0;
        bus_addr   = '0;
        bus_wrdata = '0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic rd,
                            input logic [31:0] exp);
        bus_addr = a;
        bus_rden = rd;
        #1;
        chk(tag, bus_rddata, exp);
        bus_rden = 1'b0;
        bus_addr = '0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] s;
        int          r;
        int          guard;

        // reset state
        model_reset();
        tick();
        tick();
        chk("reset_tx", {31'd0, tx}, 32'd1);
        read_chk("reset_status", A_ST, 1'b1, 32'h002);
        rst = 1'b1;
        repeat (3) tick();

        // single frame 0x55
        bus_write(A_TX, 32'hFFFF_FF55);
        chk("lat_before", {31'd0, tx}, 32'd1);
        tick();
        chk("lat_start", {31'd0, tx}, 32'd0);
        repeat (FRAME + 4) tick();
        read_chk("after_55_status", A_ST, 1'b1, 32'h002);

        // three back-to-back bytes
        bus_write(A_TX, 32'hA1);
        bus_write(A_TX, 32'hB2);
        bus_write(A_TX, 32'hC3);
        read_chk("b2b_status_model", A_ST, 1'b1, exp_status());
        bus_addr = A_ST;
        bus_rden = 1'b1;
        #1;
        s = bus_rddata;
        bus_rden = 1'b0;
        bus_addr = '0;
        chk("b2b_count", {28'd0, s[11:8]}, 32'd2);
        repeat (3 * (FRAME + 1) + 4) tick();
        read_chk("b2b_done", A_ST, 1'b1, 32'h002);

        // overflow: 1 in flight + 8 queued + 1 dropped
        for (int i = 0; i < 10; i++) bus_write(A_TX, 32'(8'h30 + i));
        read_chk("ovf_status", A_ST, 1'b1, 32'h80D);
        bus_write(A_ST, 32'h8);
        read_chk("ovf_clear", A_ST, 1'b1, 32'h805);

        // full FIFO: push on the pop edge is accepted
        guard = 0;
        while (in_frame(e_m) && guard < 200) begin
            tick();
            guard++;
        end
        read_chk("full_idle_status", A_ST, 1'b1, 32'h801);
        bus_write(A_TX, 32'h5A);
        read_chk("full_pop_push", A_ST, 1'b1, 32'h805);
        repeat (9 * (FRAME + 1) + 10) tick();
        read_chk("full_drain", A_ST, 1'b1, 32'h002);

        // read decode
        read_chk("rd_off2", BASE + 32'h8, 1'b1, 32'h0);
        read_chk("rd_off3", BASE + 32'hC, 1'b1, 32'h0);
        read_chk("rd_unsel", 32'h2000_0004, 1'b1, 32'h0);
        read_chk("rd_txdata", A_TX, 1'b1, 32'h0);
        read_chk("rd_noren", A_ST, 1'b0, 32'h0);

        // randomized traffic against the model
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 39);
            if (r < 2) begin
                bus_write(A_TX, $urandom());
            end else if (r == 2) begin
                bus_write(A_ST, $urandom());
            end else if (r == 3) begin
                a = ($urandom_range(0, 1) == 0) ? $urandom() : (BASE + 32'($urandom_range(8, 15)));
                bus_write(a, $urandom());
            end else if (r < 8) begin
                a = ($urandom_range(0, 3) == 0) ? $urandom() : (BASE + 32'($urandom_range(0, 15)));
                bus_rden = ($urandom_range(0, 3) != 0);
                read_chk("rand_read", a, bus_rden, exp_read(a, bus_rden));
            end else begin
                tick();
            end
        end
        repeat (D * (FRAME + 1) + 50) tick();
        read_chk("rand_drain", A_ST, 1'b1, exp_status());
        bus_write(A_ST, 32'h8);

        // reset mid-frame with bytes queued
        bus_write(A_TX, 32'h0F);
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        repeat (8) tick();
        read_chk("pre_rst_status", A_ST, 1'b1, 32'h304);
        rst = 1'b0;
        #1;
        chk("rst_tx_immediate", {31'd0, tx}, 32'd1);
        model_reset();
        read_chk("rst_status", A_ST, 1'b1, 32'h002);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3 * FRAME) tick();
        read_chk("post_rst_status", A_ST, 1'b1, 32'h002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
